// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding-select, load-use stall and branch-flush control for the
// 5-stage core. Keeps its own EX/MEM/WB shadow copy of register-use metadata.
module hazard_fwd_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              branch_taken,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_WB  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use1;
      logic              use2;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              mr;
   } ex_meta_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              mr;
   } mem_meta_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              we;
   } wb_meta_t;

   ex_meta_t   ex_q,  ex_d;
   mem_meta_t  mem_q, mem_d;
   wb_meta_t   wb_q,  wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             raw;

   // A stage produces register r when it is valid, writes, and r is not x0
   function automatic logic produces(input logic v, input logic we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] r);
      return v && we && (rd != '0) && (rd == r);
   endfunction

   // Operand forwarding selects: MEM (non-load) beats WB beats regfile
   always_comb begin
      fwd_a_sel = SEL_RF;
      fwd_b_sel = SEL_RF;
      if (ex_q.use1) begin
         if (produces(mem_q.v, mem_q.we, mem_q.rd, ex_q.rs1) && !mem_q.mr) fwd_a_sel = SEL_MEM;
         else if (produces(wb_q.v, wb_q.we, wb_q.rd, ex_q.rs1))           fwd_a_sel = SEL_WB;
      end
      if (ex_q.use2) begin
         if (produces(mem_q.v, mem_q.we, mem_q.rd, ex_q.rs2) && !mem_q.mr) fwd_b_sel = SEL_MEM;
         else if (produces(wb_q.v, wb_q.we, wb_q.rd, ex_q.rs2))           fwd_b_sel = SEL_WB;
      end
   end

   // Load-use detection; a taken branch squashes the consumer so it wins over stall
   always_comb begin
      raw = id_valid && ex_q.v && ex_q.mr && (ex_q.rd != '0) &&
            ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));
      flush = branch_taken;
      stall = raw && !branch_taken;
   end

   // Shadow pipeline advance and saturating counter next-state
   always_comb begin
      ex_d  = '0;
      mem_d = '{v: ex_q.v, rd: ex_q.rd, we: ex_q.we, mr: ex_q.mr};
      wb_d  = '{v: mem_q.v, rd: mem_q.rd, we: mem_q.we};
      if (!(flush || stall)) begin
         ex_d = '{v: id_valid, rs1: id_rs1, rs2: id_rs2, use1: id_use_rs1,
                  use2: id_use_rs2, rd: id_rd, we: id_regwrite, mr: id_memread};
      end
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State registers; reset discards all in-flight metadata
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed instruction sequences with hand-computed selects/stalls.
module tb_hazard_fwd_ctrl;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, branch_taken;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic [1:0]        fwd_a_sel, fwd_b_sel;
   logic              stall, flush;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .branch_taken(branch_taken),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall(stall), .flush(flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present an ID instruction (v, rs1, rs2, use1, use2, rd, we, mr) plus branch, then settle
   task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1,
                         input logic u2, input int rd, input logic we, input logic mr,
                         input logic br);
      id_valid     = v;
      id_rs1       = REG_AW'(rs1);
      id_rs2       = REG_AW'(rs2);
      id_use_rs1   = u1;
      id_use_rs2   = u2;
      id_rd        = REG_AW'(rd);
      id_regwrite  = we;
      id_memread   = mr;
      branch_taken = br;
      #2;
   endtask

   task automatic nop();
      set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin
         nop();
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      nop();
      #1;
      chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_scnt", 32'(stall_cnt), 32'd0);
      chk("rst_fcnt", 32'(flush_cnt), 32'd0);
      tick(); tick();
      rst = 1'b0;
      drain();

      // 1: add x5 ; add x6,x5,x1 -> MEM forward on A
      set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
      chk("t1_stall0", 32'(stall), 32'd0);
      tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
      chk("t1_stall1", 32'(stall), 32'd0);
      tick();
      nop();
      chk("t1_fwd_a", 32'(fwd_a_sel), 32'd2);
      chk("t1_fwd_b", 32'(fwd_b_sel), 32'd0);
      chk("t1_stall2", 32'(stall), 32'd0);
      drain();

      // 2: add x5 ; nop ; sub x7,x0,x5 -> B from WB, A regfile
      set_id(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
      nop(); tick();
      set_id(1, 0, 5, 1, 1, 7, 1, 0, 0); tick();
      nop();
      chk("t2_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("t2_fwd_b", 32'(fwd_b_sel), 32'd1);
      drain();

      // 3: addi x5 ; addi x5 ; add x8,x5,x5 -> MEM beats WB on both
      set_id(1, 5, 0, 1, 0, 5, 1, 0, 0); tick();
      set_id(1, 5, 0, 1, 0, 5, 1, 0, 0); tick();
      set_id(1, 5, 5, 1, 1, 8, 1, 0, 0); tick();
      nop();
      chk("t3_fwd_a", 32'(fwd_a_sel), 32'd2);
      chk("t3_fwd_b", 32'(fwd_b_sel), 32'd2);
      drain();

      // 4: lw x6 ; add x7,x6,x2 -> one stall, then WB forward
      set_id(1, 1, 0, 1, 0, 6, 1, 1, 0); tick();
      set_id(1, 6, 2, 1, 1, 7, 1, 0, 0);
      chk("t4_stall", 32'(stall), 32'd1);
      chk("t4_flush", 32'(flush), 32'd0);
      tick();
      chk("t4_bubble_stall", 32'(stall), 32'd0);
      chk("t4_bubble_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("t4_scnt1", 32'(stall_cnt), 32'd1);
      tick();
      nop();
      chk("t4_fwd_a", 32'(fwd_a_sel), 32'd1);
      chk("t4_fwd_b", 32'(fwd_b_sel), 32'd0);
      chk("t4_scnt2", 32'(stall_cnt), 32'd1);
      drain();

      // 5: x0 is never forwarded nor stalled on
      set_id(1, 1, 2, 1, 1, 0, 1, 0, 0); tick();
      set_id(1, 0, 0, 1, 1, 9, 1, 0, 0); tick();
      set_id(1, 1, 0, 1, 0, 0, 1, 1, 0);
      chk("t5_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("t5_fwd_b", 32'(fwd_b_sel), 32'd0);
      tick();
      set_id(1, 0, 0, 1, 0, 10, 1, 0, 0);
      chk("t5_ld_x0_stall", 32'(stall), 32'd0);
      tick();
      nop();
      chk("t5_rd_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("t5_scnt", 32'(stall_cnt), 32'd1);
      drain();

      // 6: load-use coinciding with taken branch -> flush wins, consumer squashed
      set_id(1, 1, 0, 1, 0, 6, 1, 1, 0); tick();
      set_id(1, 6, 0, 1, 0, 7, 1, 0, 1);
      chk("t6_stall", 32'(stall), 32'd0);
      chk("t6_flush", 32'(flush), 32'd1);
      tick();
      set_id(1, 7, 0, 1, 0, 11, 1, 0, 0);
      chk("t6_fcnt", 32'(flush_cnt), 32'd1);
      chk("t6_scnt", 32'(stall_cnt), 32'd1);
      chk("t6_flush_off", 32'(flush), 32'd0);
      tick();
      nop();
      chk("t6_no_fwd_squashed", 32'(fwd_a_sel), 32'd0);
      drain();

      // 6b: reset mid-stream clears everything immediately
      set_id(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
      set_id(1, 5, 0, 1, 0, 6, 1, 0, 0); tick();
      set_id(1, 1, 0, 1, 0, 6, 1, 1, 0);
      chk("t6r_pre_fwd_a", 32'(fwd_a_sel), 32'd2);
      rst = 1'b1;
      #1;
      chk("t6r_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("t6r_stall", 32'(stall), 32'd0);
      chk("t6r_scnt", 32'(stall_cnt), 32'd0);
      chk("t6r_fcnt", 32'(flush_cnt), 32'd0);
      tick();
      rst = 1'b0;
      set_id(1, 5, 6, 1, 1, 9, 1, 0, 0);
      chk("t6r_no_stall", 32'(stall), 32'd0);
      tick();
      nop();
      chk("t6r_post_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("t6r_post_fwd_b", 32'(fwd_b_sel), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
